// File: rtl/demod_amplitude.sv
// ============================================================================
// demod_amplitude
// ----------------------------------------------------------------------------
// AM envelope detector for an 8-bit offset-binary audio stream.
//
// Each valid sample is rectified around mid-scale (128). A peak hold with
// instant attack and slow linear decay tracks the result. After decay, the
// envelope is presented on env_o. A two-state hysteresis detector
// (SILENT/ACTIVE) reports signal presence on active_o. If no sample strobe
// arrives for TIMEOUT_CYCLES clocks, the envelope state is flushed to zero.
//
// Build option:
//   DEMOD_AMPLITUDE_LPF_EN  - when defined, env_o comes from a first-order IIR
//                             smoother (7.3 fixed point, alpha = 1/8) that
//                             follows the peak hold. env_val_o latency is
//                             then 2 clocks instead of 1.
//
// Parameters:
//   DECAY_SAMPLES   sub-peak valid samples per 1-LSB envelope decrement
//   TIMEOUT_CYCLES  clocks without sample_val_i before input loss
//   THRESH_ON       env_o level that declares the signal present
//   THRESH_OFF      env_o level below which the signal is absent
//                   (THRESH_OFF < THRESH_ON)
//
// Ports:
//   clk            in   clock
//   rstn           in   asynchronous active-low reset
//   sample_val_i   in   one-cycle strobe qualifying sample_data_i
//   sample_data_i  in   [7:0] unsigned offset-binary sample, 128 = zero
//   env_o          out  [6:0] envelope magnitude 0..127
//   env_val_o      out  one-cycle strobe marking each env_o update
//   active_o       out  high while the detector is in ACTIVE
// ============================================================================
module demod_amplitude #(
    parameter int unsigned DECAY_SAMPLES  = 48,
    parameter int unsigned TIMEOUT_CYCLES = 1040,
    parameter int unsigned THRESH_ON      = 16,
    parameter int unsigned THRESH_OFF     = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sample_val_i,
    input  logic [7:0] sample_data_i,
    output logic [6:0] env_o,
    output logic       env_val_o,
    output logic       active_o
);

    localparam int unsigned DW = $clog2(DECAY_SAMPLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_SAMPLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT     = TW'(TIMEOUT_CYCLES);
    localparam logic [6:0]    TH_ON      = 7'(THRESH_ON);
    localparam logic [6:0]    TH_OFF     = 7'(THRESH_OFF);

    typedef enum logic {
        SILENT = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [6:0]      mag;
    logic [6:0]      peak, peak_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic [TW-1:0]   tcnt;
    logic            timeout_hit;
    logic            sample_acc;
    logic            to_d;
    logic            env_chg;

    // ------------------------------------------------------------------
    // Rectifier: |x - 128|. The most negative code (0) would give 128,
    // which does not fit in 7 bits, so it saturates to 127.
    // ------------------------------------------------------------------
    always_comb begin
        mag = '0;
        if (sample_data_i[7]) begin
            mag = sample_data_i[6:0];
        end else if (sample_data_i == 8'd0) begin
            mag = 7'd127;
        end else begin
            mag = 7'(8'd128 - sample_data_i);
        end
    end

    // ------------------------------------------------------------------
    // Loss-of-input timer. It counts clocks since the last strobe and
    // saturates at TIMEOUT_CYCLES, so the flush fires only once per gap.
    // On the timeout cycle the flush wins over a coincident strobe. That
    // strobe is discarded and does not restart the timer.
    // ------------------------------------------------------------------
    assign timeout_hit = (tcnt == TO_LAST);
    assign sample_acc  = sample_val_i && !timeout_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt <= '0;
        end else if (sample_acc) begin
            tcnt <= '0;
        end else if (tcnt != TO_SAT) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Peak hold: instant attack, one LSB of decay every DECAY_SAMPLES
    // samples that fall below the held peak. Because mag < peak on the
    // decay path, peak - 1 can never drop below the current mag.
    // ------------------------------------------------------------------
    always_comb begin
        peak_nxt = peak;
        dcnt_nxt = dcnt;
        if (timeout_hit) begin
            peak_nxt = '0;
            dcnt_nxt = '0;
        end else if (sample_val_i) begin
            if (mag >= peak) begin
                peak_nxt = mag;
                dcnt_nxt = '0;
            end else if (dcnt == DECAY_LAST) begin
                peak_nxt = peak - 1'b1;
                dcnt_nxt = '0;
            end else begin
                dcnt_nxt = dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            peak <= '0;
            dcnt <= '0;
            to_d <= 1'b0;
        end else begin
            peak <= peak_nxt;
            dcnt <= dcnt_nxt;
            to_d <= timeout_hit;
        end
    end

`ifdef DEMOD_AMPLITUDE_LPF_EN
    // ------------------------------------------------------------------
    // Smoother: y += (peak*8 - y) >>> 3, with y in 7.3 fixed point.
    // It runs one clock behind the peak update, so it always sees the
    // peak that the triggering sample produced.
    // ------------------------------------------------------------------
    logic              val_d1;
    logic [9:0]        lpf_y;
    logic signed [10:0] lpf_diff;
    logic signed [10:0] lpf_sum;

    always_comb begin
        lpf_diff = $signed({1'b0, peak, 3'b000}) - $signed({1'b0, lpf_y});
        lpf_sum  = $signed({1'b0, lpf_y}) + (lpf_diff >>> 3);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            val_d1    <= 1'b0;
            env_val_o <= 1'b0;
            lpf_y     <= '0;
        end else if (timeout_hit) begin
            val_d1    <= 1'b0;
            env_val_o <= 1'b0;
            lpf_y     <= '0;
        end else begin
            val_d1    <= sample_acc;
            env_val_o <= val_d1;
            if (val_d1) begin
                lpf_y <= lpf_sum[9:0];
            end
        end
    end

    assign env_o = lpf_y[9:3];
`else
    // The peak register updates on the strobe edge, so it already has
    // the one-clock envelope latency and drives env_o directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            env_val_o <= 1'b0;
        end else begin
            env_val_o <= sample_acc;
        end
    end

    assign env_o = peak;
`endif

    // ------------------------------------------------------------------
    // Presence detector. It is evaluated only in the clock after env_o
    // changes (a new value or a timeout flush), so active_o trails env_o
    // by one clock.
    // ------------------------------------------------------------------
    assign env_chg = env_val_o || to_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SILENT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (env_chg) begin
            case (state)
                SILENT: if (env_o >= TH_ON) state_nxt = ACTIVE;
                ACTIVE: if (to_d || (env_o < TH_OFF)) state_nxt = SILENT;
                default: state_nxt = SILENT;
            endcase
        end
    end

    assign active_o = (state == ACTIVE);

endmodule

// File: tb/tb_demod_amplitude.sv
// ============================================================================
// tb_demod_amplitude
// ----------------------------------------------------------------------------
// Directed self-checking bench for demod_amplitude in its default build
// (DEMOD_AMPLITUDE_LPF_EN undefined, env_val_o latency 1). Expected values
// are hand-derived from the default parameters: DECAY_SAMPLES=48,
// TIMEOUT_CYCLES=1040, THRESH_ON=16, THRESH_OFF=8.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// ============================================================================
module tb_demod_amplitude;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sample_val_i;
    logic [7:0] sample_data_i;
    logic [6:0] env_o;
    logic       env_val_o;
    logic       active_o;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    always #5 clk = ~clk;

    demod_amplitude #(
        .DECAY_SAMPLES (48),
        .TIMEOUT_CYCLES(1040),
        .THRESH_ON     (16),
        .THRESH_OFF    (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_val_i (sample_val_i),
        .sample_data_i(sample_data_i),
        .env_o        (env_o),
        .env_val_o    (env_val_o),
        .active_o     (active_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at 1 ns after an edge. Returns 1 ns after the edge that
    // consumed the strobe, which is where env_o / env_val_o are new.
    task automatic send(input logic [7:0] d);
        sample_val_i  = 1'b1;
        sample_data_i = d;
        @(posedge clk);
        #1;
        sample_val_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse();
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rstn          = 1'b0;
        sample_val_i  = 1'b0;
        sample_data_i = 8'd128;
        idle(3);
        check("rst_env", int'(env_o), 0);
        check("rst_val", int'(env_val_o), 0);
        check("rst_act", int'(active_o), 0);
        rstn = 1'b1;
        idle(1);

        // Mid-scale input: envelope stays zero, one pulse per strobe.
        for (int i = 0; i < 3; i++) begin
            send(8'd128);
            check("mid_val", int'(env_val_o), 1);
            check("mid_env", int'(env_o), 0);
            idle(1);
            check("mid_val_off", int'(env_val_o), 0);
            check("mid_act", int'(active_o), 0);
        end
        send(8'd128);
        check("b2b_val0", int'(env_val_o), 1);
        send(8'd128);
        check("b2b_val1", int'(env_val_o), 1);
        idle(1);
        check("b2b_off", int'(env_val_o), 0);

        // Attack, then linear decay down through the off threshold.
        send(8'd228);
        check("atk_env", int'(env_o), 100);
        check("atk_val", int'(env_val_o), 1);
        check("atk_act_lag", int'(active_o), 0);
        idle(1);
        check("atk_act", int'(active_o), 1);
        repeat (47) begin send(8'd128); idle(1); end
        check("dec47_env", int'(env_o), 100);
        send(8'd128);
        check("dec48_env", int'(env_o), 99);
        idle(1);
        repeat (4368) begin send(8'd128); idle(1); end
        check("dec_long_env", int'(env_o), 8);
        check("dec_long_act", int'(active_o), 1);
        repeat (47) begin send(8'd128); idle(1); end
        check("dec_hold8", int'(env_o), 8);
        send(8'd128);
        check("dec_env7", int'(env_o), 7);
        check("dec_act_lag", int'(active_o), 1);
        idle(1);
        check("dec_act_off", int'(active_o), 0);

        // Hysteresis: 10 is not enough to turn on, 16 is.
        send(8'd138);
        check("hys10_env", int'(env_o), 10);
        idle(1);
        check("hys10_act", int'(active_o), 0);
        send(8'd144);
        check("hys16_env", int'(env_o), 16);
        idle(1);
        check("hys16_act", int'(active_o), 1);

        // Loss of input with envelope at 60.
        send(8'd188);
        check("to_env60", int'(env_o), 60);
        idle(1);
        repeat (4) begin send(8'd128); idle(1); end
        send(8'd128);
        pulses = 0;
        repeat (1039) begin
            @(posedge clk);
            #1;
            pulses += int'(env_val_o);
        end
        check("to_pre_env", int'(env_o), 60);
        check("to_pre_pulses", pulses, 0);
        check("to_pre_act", int'(active_o), 1);
        idle(1);
        check("to_env", int'(env_o), 0);
        check("to_val", int'(env_val_o), 0);
        idle(1);
        check("to_act", int'(active_o), 0);

        // A strobe landing on the timeout cycle is dropped.
        send(8'd178);
        check("tp_env50", int'(env_o), 50);
        idle(1039);
        check("tp_act_pre", int'(active_o), 1);
        send(8'd228);
        check("tp_env", int'(env_o), 0);
        check("tp_val", int'(env_val_o), 0);
        idle(1);
        check("tp_act", int'(active_o), 0);
        send(8'd128);
        check("tp_next_env", int'(env_o), 0);
        check("tp_next_val", int'(env_val_o), 1);
        idle(1);

        // Asynchronous reset in the middle of a decay.
        send(8'd178);
        idle(1);
        send(8'd128);
        idle(1);
        send(8'd128);
        check("ar_env_pre", int'(env_o), 50);
        #3;
        rstn = 1'b0;
        #1;
        check("ar_env", int'(env_o), 0);
        check("ar_val", int'(env_val_o), 0);
        check("ar_act", int'(active_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            pulses += int'(env_val_o);
        end
        check("ar_post_env", int'(env_o), 0);
        check("ar_post_pulses", pulses, 0);
        send(8'd128);
        check("ar_first_val", int'(env_val_o), 1);
        check("ar_first_env", int'(env_o), 0);
        send(8'd200);
        check("ar_env72", int'(env_o), 72);
        idle(1);

        // Full-scale codes at both ends.
        reset_pulse();
        send(8'd0);
        check("sat_zero", int'(env_o), 127);
        reset_pulse();
        send(8'd255);
        check("sat_255", int'(env_o), 127);
        reset_pulse();
        send(8'd1);
        check("sat_one", int'(env_o), 127);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demod_amplitude.md
DEMOD_AMPLITUDE -- requirements
Module: demod_amplitude

Interface
REQ-001 SHALL have parameter DECAY_SAMPLES, default 48: number of sub-peak valid samples per 1-LSB envelope decrement.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1040: clocks without sample_val_i before loss of input is declared.
REQ-003 SHALL have parameter THRESH_ON, default 16: envelope level at which the signal is declared present.
REQ-004 SHALL have parameter THRESH_OFF, default 8: envelope level below which the signal is declared absent; THRESH_OFF < THRESH_ON.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sample_val_i  input  1  one-cycle strobe qualifying sample_data_i (nominally 48 kHz).
REQ-008 SHALL have port sample_data_i  input  8  unsigned offset-binary audio sample; 128 = zero level.
REQ-009 SHALL have port env_o  output  7  demodulated envelope magnitude, 0..127.
REQ-010 SHALL have port env_val_o  output  1  one-cycle strobe marking each env_o update.
REQ-011 SHALL have port active_o  output  1  high while the state machine is in ACTIVE.

Function
REQ-012 SHALL rectify each valid sample: mag = |sample_data_i - 128|; sample 0 (mag 128) saturates to 127.
REQ-013 SHALL, on a valid sample with mag >= peak, load peak = mag and clear the decay counter (instant attack).
REQ-014 SHALL, on a valid sample with mag < peak, increment the decay counter; when it reaches DECAY_SAMPLES, peak decrements by 1, counter clears; peak never drops below the current mag.
REQ-015 SHALL leave peak and decay counter unchanged on cycles without sample_val_i.
REQ-016 SHALL update env_o and pulse env_val_o exactly 1 clock after sample_val_i (LPF disabled); back-to-back strobes produce back-to-back pulses.
REQ-017 SHALL count clocks since the last sample_val_i; at TIMEOUT_CYCLES, peak, filter state and env_o clear to 0 and the counter saturates; no env_val_o pulse is produced.
REQ-018 SHALL implement states SILENT and ACTIVE: SILENT->ACTIVE when env_o >= THRESH_ON; ACTIVE->SILENT when env_o < THRESH_OFF or on timeout; otherwise hold.
REQ-019 SHALL evaluate state transitions on the cycle env_o changes, so active_o follows env_o by 1 clock.
REQ-020 SHALL give timeout priority over a simultaneous sample_val_i arriving on the timeout cycle (clear first; that sample is processed normally on the next strobe only).

Reset
REQ-021 SHALL, while rstn is low, force env_o = 0, env_val_o = 0, active_o = 0, state = SILENT, peak, decay counter, timeout counter and filter state = 0.
REQ-022 SHALL, on reset asserted mid-operation, clear immediately and asynchronously; first env_val_o after release follows the first post-reset sample_val_i.

Configuration
REQ-023 SHALL, when DEMOD_AMPLITUDE_LPF_EN is defined, drive env_o from a first-order IIR: y += (peak - y) >>> 3 per valid sample, 10-bit internal accumulator (7.3 fixed point), env_o = integer part; env_val_o latency becomes 2 clocks.
REQ-024 SHALL, when DEMOD_AMPLITUDE_LPF_EN is not defined, drive env_o directly from peak with latency 1 and instantiate no filter registers.
REQ-025 SHALL use env_o (post-filter when enabled) for state-machine thresholds in both builds.

Verification
REQ-026 Constant samples 128 at 48 kHz -> env_o = 0, active_o stays 0, env_val_o pulses once per strobe, 1 clock after it.
REQ-027 Single sample 228 after silence (LPF off) -> env_o = 100 next clock, active_o = 1 one clock later; then 48 samples of 128 -> env_o = 99; 4368 samples -> env_o = 8, one more decrement to 7 -> active_o = 0.
REQ-028 Samples 0 and 255 -> env_o = 127 for both (saturation of 0 case).
REQ-029 Stop sample_val_i with env_o = 60 -> after 1040 clocks env_o = 0, active_o = 0, no env_val_o pulse.
REQ-030 Assert rstn low mid-decay with env_o = 50 -> all outputs 0 within the same cycle; after release, env_o = 0 until next strobe.
REQ-031 LPF build, step from 0 to peak 64 -> env_o = 8, 15, 21, ... monotonically approaching 64, env_val_o 2 clocks after each strobe.
